// File: rtl/rv_sequence_checker.sv
// +-----------------------------------------------------------------------------+
// | Module      : rv_sequence_checker                                           |
// | Description : Ready/valid sink that checks beats against an arithmetic      |
// |               sequence and counts transfers, mismatches and protocol        |
// |               violations. Optional macro RV_CHK_BACKPRESSURE_EN adds        |
// |               LFSR-driven ready throttling.                                 |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module rv_sequence_checker #(
   parameter int                    DATA_WIDTH    = 8,
   parameter logic [DATA_WIDTH-1:0] SEED          = '0,
   parameter logic [DATA_WIDTH-1:0] STEP          = DATA_WIDTH'(1),
   parameter int                    MAX_TRANSFERS = 0,
   parameter int                    CNT_WIDTH     = 16,
   parameter bit                    RESYNC        = 1'b0
) (
   input  logic                  clock_port,
   input  logic                  reset_port,
   input  logic [DATA_WIDTH-1:0] input_port_data,
   input  logic                  input_port_valid,
   output logic                  input_port_ready,
   output logic [CNT_WIDTH-1:0]  transfer_count,
   output logic [CNT_WIDTH-1:0]  error_count,
   output logic                  error_flag,
   output logic [DATA_WIDTH-1:0] first_err_data,
   output logic [DATA_WIDTH-1:0] first_err_exp,
   output logic                  protocol_error,
   output logic                  done
);

   localparam logic [31:0] C_MAX_TRANSFERS = 32'(MAX_TRANSFERS);
   localparam bit          C_LIMITED       = (MAX_TRANSFERS != 0);

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic                  w_ready;
   logic                  w_throttle;
   logic                  w_in_run;
   logic                  w_transfer;
   logic                  w_last_beat;
   logic                  w_mismatch;
   logic                  w_proto_violation;

   logic [DATA_WIDTH-1:0] r_expected;
   logic [CNT_WIDTH-1:0]  r_transfer_count;
   logic [CNT_WIDTH-1:0]  r_error_count;
   logic                  r_error_flag;
   logic [DATA_WIDTH-1:0] r_first_err_data;
   logic [DATA_WIDTH-1:0] r_first_err_exp;
   logic                  r_protocol_error;
   logic                  r_prev_valid;
   logic                  r_prev_ready;
   logic [DATA_WIDTH-1:0] r_prev_data;

`ifdef RV_CHK_BACKPRESSURE_EN
   // Fibonacci LFSR, taps 16,14,13,11; ready is low whenever the two LSBs are zero.
   logic [15:0] r_lfsr;
   logic        w_lfsr_fb;

   assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

   always_ff @(posedge clock_port) begin
      if (reset_port) begin
         r_lfsr <= 16'hACE1;
      end else if (r_state == ST_RUN) begin
         r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
      end
   end

   assign w_throttle = (r_lfsr[1:0] != 2'b00);
`else
   assign w_throttle = 1'b1;
`endif

   // Ready is a function of registered state only, so no valid->ready path exists.
   assign w_in_run    = (r_state == ST_RUN);
   assign w_transfer  = input_port_valid & w_in_run & w_throttle;
   assign w_last_beat = C_LIMITED && ((32'(r_transfer_count) + 32'd1) == C_MAX_TRANSFERS);

   always_ff @(posedge clock_port) begin
      if (reset_port) begin
         r_state <= ST_HOLD;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_ready      = 1'b0;
      case (r_state)
         ST_HOLD: begin
            w_state_next = ST_RUN;
         end
         ST_RUN: begin
            w_ready = w_throttle;
            if (w_transfer && w_last_beat) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_next = ST_DONE;
         end
         default: begin
            w_state_next = ST_HOLD;
         end
      endcase
   end

   // Written as if/else so an unknown compare result counts as a mismatch.
   always_comb begin
      w_mismatch = 1'b1;
      if (input_port_data == r_expected) begin
         w_mismatch = 1'b0;
      end
   end

   assign w_proto_violation = w_in_run && r_prev_valid && !r_prev_ready &&
                              (!input_port_valid || (input_port_data != r_prev_data));

   always_ff @(posedge clock_port) begin
      if (reset_port) begin
         r_expected       <= SEED;
         r_transfer_count <= '0;
         r_error_count    <= '0;
         r_error_flag     <= 1'b0;
         r_first_err_data <= '0;
         r_first_err_exp  <= '0;
         r_protocol_error <= 1'b0;
         r_prev_valid     <= 1'b0;
         r_prev_ready     <= 1'b0;
         r_prev_data      <= '0;
      end else begin
         // Only beats offered while running are tracked for the hold-stable rule.
         r_prev_valid <= input_port_valid & w_in_run;
         r_prev_ready <= w_ready;
         r_prev_data  <= input_port_data;

         if (w_proto_violation) begin
            r_protocol_error <= 1'b1;
         end

         if (w_transfer) begin
            if (r_transfer_count != '1) begin
               r_transfer_count <= r_transfer_count + 1'b1;
            end
            r_expected <= r_expected + STEP;

            if (w_mismatch) begin
               if (r_error_count != '1) begin
                  r_error_count <= r_error_count + 1'b1;
               end
               r_error_flag <= 1'b1;
               if (!r_error_flag) begin
                  r_first_err_data <= input_port_data;
                  r_first_err_exp  <= r_expected;
               end
               if (RESYNC) begin
                  r_expected <= input_port_data + STEP;
               end
            end
         end
      end
   end

   assign input_port_ready = w_ready;
   assign transfer_count   = r_transfer_count;
   assign error_count      = r_error_count;
   assign error_flag       = r_error_flag;
   assign first_err_data   = r_first_err_data;
   assign first_err_exp    = r_first_err_exp;
   assign protocol_error   = r_protocol_error;
   assign done             = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_rv_sequence_checker.sv
// +-----------------------------------------------------------------------------+
// | Module      : tb_rv_sequence_checker                                        |
// | Description : Scoreboard bench for rv_sequence_checker (three configs).     |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_rv_sequence_checker;

   typedef struct packed {
      logic [15:0] tc;
      logic [15:0] ec;
      logic        ef;
      logic [7:0]  fed;
      logic [7:0]  fee;
      logic        pe;
      logic        dn;
   } rec_t;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       valid = 1'b0;
   logic [7:0] data  = 8'h00;
   int         sel   = 0;
   bit         mon_en = 1'b1;

   logic        vld [3];
   logic        rdy [3];
   logic [15:0] tc  [3];
   logic [15:0] ec  [3];
   logic        ef  [3];
   logic [7:0]  fed [3];
   logic [7:0]  fee [3];
   logic        pe  [3];
   logic        dn  [3];

   rec_t sb [$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   n_beat = 0;
   bit   pending = 1'b0;
   rec_t m_exp;
   rec_t m_act;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         vld[i] = valid && (sel == i);
      end
   end

   // a: defaults; r: resync on mismatch; w: wrap-around seed with a 4-beat limit.
   rv_sequence_checker #(.DATA_WIDTH(8), .SEED(8'h00), .STEP(8'h01), .MAX_TRANSFERS(0),
                         .CNT_WIDTH(16), .RESYNC(1'b0)) u_dut_a (
      .clock_port(clk), .reset_port(rst), .input_port_data(data), .input_port_valid(vld[0]),
      .input_port_ready(rdy[0]), .transfer_count(tc[0]), .error_count(ec[0]), .error_flag(ef[0]),
      .first_err_data(fed[0]), .first_err_exp(fee[0]), .protocol_error(pe[0]), .done(dn[0]));

   rv_sequence_checker #(.DATA_WIDTH(8), .SEED(8'h00), .STEP(8'h01), .MAX_TRANSFERS(0),
                         .CNT_WIDTH(16), .RESYNC(1'b1)) u_dut_r (
      .clock_port(clk), .reset_port(rst), .input_port_data(data), .input_port_valid(vld[1]),
      .input_port_ready(rdy[1]), .transfer_count(tc[1]), .error_count(ec[1]), .error_flag(ef[1]),
      .first_err_data(fed[1]), .first_err_exp(fee[1]), .protocol_error(pe[1]), .done(dn[1]));

   rv_sequence_checker #(.DATA_WIDTH(8), .SEED(8'hFE), .STEP(8'h01), .MAX_TRANSFERS(4),
                         .CNT_WIDTH(16), .RESYNC(1'b0)) u_dut_w (
      .clock_port(clk), .reset_port(rst), .input_port_data(data), .input_port_valid(vld[2]),
      .input_port_ready(rdy[2]), .transfer_count(tc[2]), .error_count(ec[2]), .error_flag(ef[2]),
      .first_err_data(fed[2]), .first_err_exp(fee[2]), .protocol_error(pe[2]), .done(dn[2]));

   // Monitor: a transfer seen at one negedge is checked at the next one.
   always @(negedge clk) begin
      if (pending) begin
         pending = 1'b0;
         n_cmp++;
         n_beat++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow: beat %0d accepted with no expected entry", n_beat);
         end else begin
            m_exp = sb.pop_front();
            m_act = {tc[sel], ec[sel], ef[sel], fed[sel], fee[sel], pe[sel], dn[sel]};
            if (m_act !== m_exp) begin
               n_fail++;
               $display("FAIL beat%0d: got tc=%0d ec=%0d ef=%0b fed=%h fee=%h pe=%0b done=%0b, need tc=%0d ec=%0d ef=%0b fed=%h fee=%h pe=%0b done=%0b",
                        n_beat, m_act.tc, m_act.ec, m_act.ef, m_act.fed, m_act.fee, m_act.pe, m_act.dn,
                        m_exp.tc, m_exp.ec, m_exp.ef, m_exp.fed, m_exp.fee, m_exp.pe, m_exp.dn);
            end
         end
      end
      pending = mon_en && !rst && valid && rdy[sel];
   end

   function automatic rec_t r(input int t, input int e, input bit f,
                              input logic [7:0] a, input logic [7:0] b, input bit d);
      return {16'(t), 16'(e), f, a, b, 1'b0, d};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h need %0h", name, act, exp);
      end
   endtask

   // Apply reset, check cleared outputs, release and check HOLD (ready low).
   task automatic reset_dut(input int which);
      @(posedge clk); #1;
      sel = which; valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      check("rst_counts", {tc[sel], ec[sel]}, 32'h0);
      check("rst_flags", {28'h0, ef[sel], pe[sel], dn[sel], rdy[sel]}, 32'h0);
      check("rst_first_err", {16'h0, fed[sel], fee[sel]}, 32'h0);
      rst = 1'b0;
      check("hold_ready", {31'h0, rdy[sel]}, 32'h0);
   endtask

   task automatic send(input logic [7:0] d, input rec_t e);
      int t;
      sb.push_back(e);
      data  = d;
      valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!rdy[sel] && t < 200) begin
         t++;
         @(negedge clk);
      end
      if (!rdy[sel]) begin
         n_cmp++;
         n_fail++;
         $display("FAIL ready_timeout: ready stayed %0b, need 1", rdy[sel]);
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // In-order stream on the default config.
      reset_dut(0);
      for (int i = 0; i < 10; i++) begin
         send(8'(i), r(i + 1, 0, 1'b0, 8'h00, 8'h00, 1'b0));
      end
      idle(2);
      check("t1_count", {16'h0, tc[0]}, 32'd10);

      // Single corrupted beat, no resync: 7 replaces 3, then 4 matches again.
      reset_dut(0);
      send(8'd0, r(1, 0, 1'b0, 8'h00, 8'h00, 1'b0));
      send(8'd1, r(2, 0, 1'b0, 8'h00, 8'h00, 1'b0));
      send(8'd2, r(3, 0, 1'b0, 8'h00, 8'h00, 1'b0));
      send(8'd7, r(4, 1, 1'b1, 8'h07, 8'h03, 1'b0));
      send(8'd4, r(5, 1, 1'b1, 8'h07, 8'h03, 1'b0));
      idle(2);

      // Reset mid-stream with error_flag set and a beat offered.
      data = 8'd5; valid = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_counts", {tc[0], ec[0]}, 32'h0);
      check("mid_rst_flags", {28'h0, ef[0], pe[0], dn[0], rdy[0]}, 32'h0);
      check("mid_rst_first_err", {16'h0, fed[0], fee[0]}, 32'h0);
      rst = 1'b0; valid = 1'b0;
      check("mid_rst_hold", {31'h0, rdy[0]}, 32'h0);
      send(8'd0, r(1, 0, 1'b0, 8'h00, 8'h00, 1'b0));
      idle(2);

      // Resync config: after 7 the expectation becomes 8, so 4 is a second error.
      reset_dut(1);
      send(8'd0, r(1, 0, 1'b0, 8'h00, 8'h00, 1'b0));
      send(8'd1, r(2, 0, 1'b0, 8'h00, 8'h00, 1'b0));
      send(8'd2, r(3, 0, 1'b0, 8'h00, 8'h00, 1'b0));
      send(8'd7, r(4, 1, 1'b1, 8'h07, 8'h03, 1'b0));
      send(8'd4, r(5, 2, 1'b1, 8'h07, 8'h03, 1'b0));
      send(8'd5, r(6, 2, 1'b1, 8'h07, 8'h03, 1'b0));
      idle(2);

      // Wrap-around from FE plus the 4-beat limit.
      reset_dut(2);
      send(8'hFE, r(1, 0, 1'b0, 8'h00, 8'h00, 1'b0));
      send(8'hFF, r(2, 0, 1'b0, 8'h00, 8'h00, 1'b0));
      send(8'h00, r(3, 0, 1'b0, 8'h00, 8'h00, 1'b0));
      send(8'h01, r(4, 0, 1'b0, 8'h00, 8'h00, 1'b1));
      data = 8'h02; valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("done_ready_low", {31'h0, rdy[2]}, 32'h0);
      end
      @(posedge clk); #1;
      check("done_count_held", {16'h0, tc[2]}, 32'd4);
      check("done_flag", {31'h0, dn[2]}, 32'h1);
      idle(2);

`ifdef RV_CHK_BACKPRESSURE_EN
      mon_en = 1'b0;
      // Data changed while stalled.
      reset_dut(0);
      data = 8'd5; valid = 1'b1;
      @(posedge clk);
      begin
         int t = 0;
         @(negedge clk);
         while (rdy[0] && t < 200) begin t++; @(negedge clk); end
      end
      @(posedge clk); #1;
      check("proto_clean", {31'h0, pe[0]}, 32'h0);
      data = 8'd6;
      @(posedge clk); #1;
      check("proto_data_change", {31'h0, pe[0]}, 32'h1);
      idle(1);
      // Valid dropped while stalled.
      reset_dut(0);
      data = 8'd5; valid = 1'b1;
      @(posedge clk);
      begin
         int t = 0;
         @(negedge clk);
         while (rdy[0] && t < 200) begin t++; @(negedge clk); end
      end
      @(posedge clk); #1;
      valid = 1'b0;
      @(posedge clk); #1;
      check("proto_valid_drop", {31'h0, pe[0]}, 32'h1);
      idle(2);
      mon_en = 1'b1;
`endif

      check("sb_drained", 32'(sb.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
